// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotation scheduler.
package cordic_pkg;

   localparam int unsigned CORDIC_LATENCY = 16;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned ANGLE_W        = 32;
   localparam int unsigned TAG_ID_W       = 4;

   localparam logic [ANGLE_W-1:0] ANG_45 = 32'h2000_0000;
   localparam logic [ANGLE_W-1:0] ANG_90 = 32'h4000_0000;

   // Per-operation bookkeeping that travels alongside the CORDIC data
   typedef struct packed {
      logic                valid;
      logic                src;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves only on an accepted grant.
module rr_arb2 (
   input  logic       clock,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);

   logic last1_q;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last1_q)) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

   // Reset value pretends req1 went last so req0 wins the first tie
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         last1_q <= 1'b1;
      end else if (adv) begin
         last1_q <= gnt[1];
      end
   end

endmodule

// File: rtl/cordic_sched.sv
// Two-requester scheduler for the shared pipelined CORDIC: arbitrates, issues,
// tracks in-flight operations with a tag pipeline and routes results back.
module cordic_sched
   import cordic_pkg::*;
#(
   parameter int unsigned LATENCY = CORDIC_LATENCY,
   parameter int unsigned ID_W    = TAG_ID_W,
   parameter int unsigned MAX_OUT = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [DATA_W-1:0]   req0_x,
   input  logic [DATA_W-1:0]   req0_y,
   input  logic [ANGLE_W-1:0]  req0_z,
   input  logic [ID_W-1:0]     req0_id,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [DATA_W-1:0]   req1_x,
   input  logic [DATA_W-1:0]   req1_y,
   input  logic [ANGLE_W-1:0]  req1_z,
   input  logic [ID_W-1:0]     req1_id,
   output logic [DATA_W-1:0]   cor_x,
   output logic [DATA_W-1:0]   cor_y,
   output logic [ANGLE_W-1:0]  cor_z,
   input  logic [DATA_W-1:0]   cor_xout,
   input  logic [DATA_W-1:0]   cor_yout,
   output logic                rsp0_valid,
   output logic [DATA_W-1:0]   rsp0_x,
   output logic [DATA_W-1:0]   rsp0_y,
   output logic [ID_W-1:0]     rsp0_id,
   output logic                rsp1_valid,
   output logic [DATA_W-1:0]   rsp1_x,
   output logic [DATA_W-1:0]   rsp1_y,
   output logic [ID_W-1:0]     rsp1_id,
   output logic                busy
);

   // Issue stage plus LATENCY+1 stages: the CORDIC registers its input one edge
   // after issue, so its result lines up with the final tag stage.
   localparam int unsigned NSTG = LATENCY + 2;

   tag_t               tag_q [NSTG];
   tag_t               tag_d [NSTG];
   tag_t               tag_last;
   logic [CNT_W-1:0]   cnt0_q, cnt1_q, cnt0_d, cnt1_d;
   logic [1:0]         elig, gnt;
   logic [DATA_W-1:0]  cor_x_d, cor_y_d;
   logic [ANGLE_W-1:0] cor_z_d;
   logic               busy_d;

   // Only the registered count gates eligibility
   always_comb begin
      elig[0] = req0_valid && (cnt0_q < CNT_W'(MAX_OUT));
      elig[1] = req1_valid && (cnt1_q < CNT_W'(MAX_OUT));
   end

   rr_arb2 u_arb (
      .clock (clock),
      .rst_n (rst_n),
      .req   (elig),
      .adv   (|gnt),
      .gnt   (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign tag_last   = tag_q[NSTG-1];

   always_comb begin
      tag_d[0] = '0;
      cor_x_d  = '0;
      cor_y_d  = '0;
      cor_z_d  = '0;
      if (gnt[0]) begin
         tag_d[0] = '{valid: 1'b1, src: 1'b0, id: req0_id};
         cor_x_d  = req0_x;
         cor_y_d  = req0_y;
         cor_z_d  = req0_z;
      end else if (gnt[1]) begin
         tag_d[0] = '{valid: 1'b1, src: 1'b1, id: req1_id};
         cor_x_d  = req1_x;
         cor_y_d  = req1_y;
         cor_z_d  = req1_z;
      end
      for (int unsigned i = 1; i < NSTG; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      // A slot is released one edge after its response strobe
      cnt0_d = cnt0_q;
      case ({gnt[0], rsp0_valid})
         2'b10:   cnt0_d = cnt0_q + CNT_W'(1);
         2'b01:   cnt0_d = cnt0_q - CNT_W'(1);
         default: cnt0_d = cnt0_q;
      endcase
      cnt1_d = cnt1_q;
      case ({gnt[1], rsp1_valid})
         2'b10:   cnt1_d = cnt1_q + CNT_W'(1);
         2'b01:   cnt1_d = cnt1_q - CNT_W'(1);
         default: cnt1_d = cnt1_q;
      endcase

      busy_d = (cnt0_d != '0) || (cnt1_d != '0);
      for (int unsigned i = 0; i < NSTG; i++) begin
         busy_d = busy_d || tag_d[i].valid;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NSTG; i++) begin
            tag_q[i] <= '0;
         end
         cnt0_q     <= '0;
         cnt1_q     <= '0;
         cor_x      <= '0;
         cor_y      <= '0;
         cor_z      <= '0;
         rsp0_valid <= 1'b0;
         rsp0_x     <= '0;
         rsp0_y     <= '0;
         rsp0_id    <= '0;
         rsp1_valid <= 1'b0;
         rsp1_x     <= '0;
         rsp1_y     <= '0;
         rsp1_id    <= '0;
         busy       <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NSTG; i++) begin
            tag_q[i] <= tag_d[i];
         end
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         cor_x      <= cor_x_d;
         cor_y      <= cor_y_d;
         cor_z      <= cor_z_d;
         busy       <= busy_d;
         rsp0_valid <= tag_last.valid && !tag_last.src;
         rsp1_valid <= tag_last.valid && tag_last.src;
         if (tag_last.valid && !tag_last.src) begin
            rsp0_x  <= cor_xout;
            rsp0_y  <= cor_yout;
            rsp0_id <= tag_last.id;
         end
         if (tag_last.valid && tag_last.src) begin
            rsp1_x  <= cor_xout;
            rsp1_y  <= cor_yout;
            rsp1_id <= tag_last.id;
         end
      end
   end

   // Counter sanity: eligibility gating should make these unreachable
   always @(posedge clock) begin
      if (rst_n) begin
         assert (!(rsp0_valid && !gnt[0] && cnt0_q == '0)) else $error("cnt0 underflow");
         assert (!(rsp1_valid && !gnt[1] && cnt1_q == '0)) else $error("cnt1 underflow");
         assert (!(gnt[0] && !rsp0_valid && cnt0_q >= CNT_W'(MAX_OUT))) else $error("cnt0 overflow");
         assert (!(gnt[1] && !rsp1_valid && cnt1_q >= CNT_W'(MAX_OUT))) else $error("cnt1 overflow");
      end
   end

endmodule
